// File: rtl/uart_tx_fifo_if.sv
// Host-to-transmitter byte handshake.
// Byte moves on the edge where tdata_valid && tdata_ready.
interface uart_tx_fifo_if;
  logic [7:0] tdata;
  logic       tdata_valid;
  logic       tdata_ready;

  modport master (
    output tdata,
    output tdata_valid,
    input  tdata_ready
  );

  modport slave (
    input  tdata,
    input  tdata_valid,
    output tdata_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN for 8E1 frames with an even parity bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 108,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  uart_tx_fifo_if.slave            s,
  output logic                     uart_tx,
  output logic                     tx_busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic full;
  logic push;
  logic pop;
  logic wrap;

  assign full          = (cnt_q == FULL);
  assign s.tdata_ready = !full;
  assign uart_tx       = tx_q;
  assign fifo_count    = cnt_q;
  assign tx_busy       = (state_q != IDLE)
                      || (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    pop     = 1'b0;
    push    = s.tdata_valid && !full;
    wrap    = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = wrap ? 8'd0 : baud_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        pop  = (cnt_q != '0);
      end
      START: begin
        if (wrap) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (wrap) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (wrap) begin
          // Back-to-back: next start bit on the stop-end edge
          if (cnt_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d = START;
      baud_d  = 8'd0;
      sh_d    = mem_q[rd_q];
      tx_d    = 1'b0;
      rd_d    = rd_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_q];
`endif
    end

    if (push) begin
      mem_d[wr_q] = s.tdata;
      wr_d        = wr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Storage needs no reset: pointers define what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
